// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between the fetch
// stage and the memory stage. Data requests win over fetch requests, one
// transaction is in flight at a time, and a watchdog aborts transactions the
// memory never acknowledges so the pipeline cannot deadlock.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          IReqF,
    input  logic [AW-1:0] IAddrF,
    output logic [DW-1:0] IRdataF,
    output logic          IReadyF,
    input  logic          DReqM,
    input  logic          DWeM,
    input  logic [AW-1:0] DAddrM,
    input  logic [DW-1:0] DWdataM,
    output logic [DW-1:0] DRdataM,
    output logic          DReadyM,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    input  logic [DW-1:0] MemRdata,
    input  logic          MemAck,
    output logic          StallFMem,
    output logic          StallMMem,
    output logic          MemErr
);

    localparam int             WDW     = $clog2(TIMEOUT + 1);
    // Last watchdog value before abort: the busy state lasts at most TIMEOUT cycles.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t         state_q,  state_d;
    logic           sel_d_q,  sel_d_d;     // 1 when the current transaction belongs to the data port
    logic           req_q,    req_d;
    logic           we_q,     we_d;
    logic [AW-1:0]  addr_q,   addr_d;
    logic [DW-1:0]  wdata_q,  wdata_d;
    logic [DW-1:0]  irdata_q, irdata_d;
    logic [DW-1:0]  drdata_q, drdata_d;
    logic           err_q,    err_d;
    logic [WDW-1:0] wdog_q,   wdog_d;

    // State and datapath registers; reset drops MemReq asynchronously.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            sel_d_q  <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_d_q  <= sel_d_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

    // Grant, completion and watchdog next-state logic.
    always_comb begin
        state_d  = state_q;
        sel_d_d  = sel_d_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        err_d    = err_q;
        wdog_d   = wdog_q;
        case (state_q)
            IDLE: begin
                if (DReqM) begin
                    state_d = BUSY_D;
                    sel_d_d = 1'b1;
                    req_d   = 1'b1;
                    we_d    = DWeM;
                    addr_d  = DAddrM;
                    wdata_d = DWdataM;
                    wdog_d  = '0;
                end else if (IReqF) begin
                    state_d = BUSY_I;
                    sel_d_d = 1'b0;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = IAddrF;
                    wdog_d  = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (MemAck) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        if (state_q == BUSY_I) irdata_d = MemRdata;
                        else                   drdata_d = MemRdata;
                    end
                end else if (wdog_q == WD_LAST) begin
                    // Abort: report the error and complete with zero read data.
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (!we_q) begin
                        if (state_q == BUSY_I) irdata_d = '0;
                        else                   drdata_d = '0;
                    end
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready pulses decode the registered DONE state, so they are glitch-free.
    assign IReadyF   = (state_q == DONE) && !sel_d_q;
    assign DReadyM   = (state_q == DONE) &&  sel_d_q;
    assign IRdataF   = irdata_q;
    assign DRdataM   = drdata_q;
    assign MemReq    = req_q;
    assign MemWe     = we_q;
    assign MemAddr   = addr_q;
    assign MemWdata  = wdata_q;
    assign MemErr    = err_q;
    // Stalls are combinational so the hazard unit sees them in the request's first cycle.
    assign StallFMem = IReqF & ~IReadyF;
    assign StallMMem = DReqM & ~DReadyM;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4.
module tb_mem_port_arbiter;

    logic        clk;
    logic        Reset;
    logic        IReqF;
    logic [31:0] IAddrF;
    logic [31:0] IRdataF;
    logic        IReadyF;
    logic        DReqM;
    logic        DWeM;
    logic [31:0] DAddrM;
    logic [31:0] DWdataM;
    logic [31:0] DRdataM;
    logic        DReadyM;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [31:0] MemRdata;
    logic        MemAck;
    logic        StallFMem;
    logic        StallMMem;
    logic        MemErr;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .Reset(Reset),
        .IReqF(IReqF), .IAddrF(IAddrF), .IRdataF(IRdataF), .IReadyF(IReadyF),
        .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM),
        .DRdataM(DRdataM), .DReadyM(DReadyM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemRdata(MemRdata), .MemAck(MemAck),
        .StallFMem(StallFMem), .StallMMem(StallMMem), .MemErr(MemErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0; IReqF = 1'b1; IAddrF = 32'h100;
        DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h200; DWdataM = 32'h1111_1111;
        MemRdata = 32'h0; MemAck = 1'b0;

        // Reset with both requests high
        tick(); tick();
        chk("rst_memreq",  32'(MemReq), 32'd0);
        chk("rst_memwe",   32'(MemWe), 32'd0);
        chk("rst_memaddr", MemAddr, 32'h0);
        chk("rst_wdata",   MemWdata, 32'h0);
        chk("rst_irdata",  IRdataF, 32'h0);
        chk("rst_drdata",  DRdataM, 32'h0);
        chk("rst_iready",  32'(IReadyF), 32'd0);
        chk("rst_dready",  32'(DReadyM), 32'd0);
        chk("rst_err",     32'(MemErr), 32'd0);
        chk("rst_stallf",  32'(StallFMem), 32'd1);
        Reset = 1'b1;

        // Priority: data granted first
        tick();
        chk("pri_memreq",  32'(MemReq), 32'd1);
        chk("pri_addr_d",  MemAddr, 32'h200);
        chk("pri_we_d",    32'(MemWe), 32'd0);
        chk("pri_stallf1", 32'(StallFMem), 32'd1);
        chk("pri_stallm1", 32'(StallMMem), 32'd1);
        MemAck = 1'b1; MemRdata = 32'hCAFE_0001;
        tick();
        chk("pri_dready",  32'(DReadyM), 32'd1);
        chk("pri_iready0", 32'(IReadyF), 32'd0);
        chk("pri_drdata",  DRdataM, 32'hCAFE_0001);
        chk("pri_reqdrop", 32'(MemReq), 32'd0);
        chk("pri_stallm0", 32'(StallMMem), 32'd0);
        chk("pri_stallf2", 32'(StallFMem), 32'd1);
        DReqM = 1'b0; MemAck = 1'b0;
        tick();
        chk("pri_dpulse1", 32'(DReadyM), 32'd0);
        chk("pri_idle_rq", 32'(MemReq), 32'd0);
        chk("pri_stallf3", 32'(StallFMem), 32'd1);
        tick();
        chk("pri_ireq",    32'(MemReq), 32'd1);
        chk("pri_addr_i",  MemAddr, 32'h100);
        MemAck = 1'b1; MemRdata = 32'h1234_5678;
        tick();
        chk("pri_iready",  32'(IReadyF), 32'd1);
        chk("pri_irdata",  IRdataF, 32'h1234_5678);
        chk("pri_drkeep",  DRdataM, 32'hCAFE_0001);
        IReqF = 1'b0; MemAck = 1'b0;
        tick();
        chk("pri_ipulse1", 32'(IReadyF), 32'd0);

        // Single fetch, MemAck in the third busy cycle
        IReqF = 1'b1; IAddrF = 32'h100;
        #1;
        chk("f_stall_req", 32'(StallFMem), 32'd1);
        tick();
        chk("f_memreq",    32'(MemReq), 32'd1);
        chk("f_addr",      MemAddr, 32'h100);
        tick();
        chk("f_stall_b2",  32'(StallFMem), 32'd1);
        tick();
        chk("f_memreq_b3", 32'(MemReq), 32'd1);
        MemAck = 1'b1; MemRdata = 32'hE3A0_1005;
        tick();
        chk("f_iready",    32'(IReadyF), 32'd1);
        chk("f_irdata",    IRdataF, 32'hE3A0_1005);
        chk("f_stall_rdy", 32'(StallFMem), 32'd0);
        IReqF = 1'b0; MemAck = 1'b0;
        tick();
        chk("f_pulse1",    32'(IReadyF), 32'd0);

        // Write: Mem* latched and stable, DRdataM unchanged
        DReqM = 1'b1; DWeM = 1'b1; DAddrM = 32'h204; DWdataM = 32'hDEAD_BEEF;
        tick();
        chk("w_we",        32'(MemWe), 32'd1);
        chk("w_wdata",     MemWdata, 32'hDEAD_BEEF);
        chk("w_addr",      MemAddr, 32'h204);
        DWdataM = 32'h0; DAddrM = 32'h0;
        tick();
        chk("w_we_hold",   32'(MemWe), 32'd1);
        chk("w_wd_hold",   MemWdata, 32'hDEAD_BEEF);
        chk("w_ad_hold",   MemAddr, 32'h204);
        MemAck = 1'b1; MemRdata = 32'h5555_5555;
        tick();
        chk("w_dready",    32'(DReadyM), 32'd1);
        chk("w_drkeep",    DRdataM, 32'hCAFE_0001);
        DReqM = 1'b0; DWeM = 1'b0; MemAck = 1'b0;
        tick();
        chk("w_pulse1",    32'(DReadyM), 32'd0);

        // Timeout: read never acknowledged
        DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h300;
        tick();
        chk("t_req1",      32'(MemReq), 32'd1);
        tick();
        tick();
        tick();
        chk("t_req4",      32'(MemReq), 32'd1);
        chk("t_err0",      32'(MemErr), 32'd0);
        chk("t_dready0",   32'(DReadyM), 32'd0);
        tick();
        chk("t_reqdrop",   32'(MemReq), 32'd0);
        chk("t_err1",      32'(MemErr), 32'd1);
        chk("t_dready",    32'(DReadyM), 32'd1);
        chk("t_drdata0",   DRdataM, 32'h0);
        DReqM = 1'b0;
        tick();
        tick();
        chk("t_err_stky",  32'(MemErr), 32'd1);
        chk("t_pulse1",    32'(DReadyM), 32'd0);

        // Reset during BUSY_I
        IReqF = 1'b1; IAddrF = 32'h400;
        tick();
        chk("r_req",       32'(MemReq), 32'd1);
        tick();
        Reset = 1'b0;
        #1;
        chk("r_req_async", 32'(MemReq), 32'd0);
        chk("r_err_clr",   32'(MemErr), 32'd0);
        MemAck = 1'b1;
        tick();
        chk("r_noready",   32'(IReadyF), 32'd0);
        Reset = 1'b1; MemAck = 1'b0;
        tick();
        chk("r_newreq",    32'(MemReq), 32'd1);
        chk("r_newaddr",   MemAddr, 32'h400);
        MemAck = 1'b1; MemRdata = 32'hA5A5_A5A5;
        tick();
        chk("r_iready",    32'(IReadyF), 32'd1);
        chk("r_irdata",    IRdataF, 32'hA5A5_A5A5);
        IReqF = 1'b0; MemAck = 1'b0;
        tick();
        chk("r_pulse1",    32'(IReadyF), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
